bfloat_add_arb: RTL and testbench

//   Shares one bfloat16 adder (bfloat_add_comb) among NREQ requesters, e.g. the
//   per-lane accumulators of a CNN PE row. Picks one request per cycle by

---
 rtl/bfloat_pkg.sv | 20 ++
 rtl/bfloat_add_comb.sv | 67 ++++++
 rtl/rr_arb.sv | 34 +++
 rtl/bfloat_add_arb.sv | 73 +++++++
 tb/tb_bfloat_add_arb.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/bfloat_pkg.sv
// Shared bfloat16 constants and operand types.
package bfloat_pkg;
  localparam int          BF16_W    = 16;
  localparam logic [15:0] BF16_ZERO = 16'h0000;
  localparam logic [15:0] BF16_ONE  = 16'h3F80;
  localparam logic [15:0] BF16_NAN  = 16'hFFFF;

  typedef logic [BF16_W-1:0] bf16_t;

  // Operand pair as captured by the shared adder.
  typedef struct packed {
    bf16_t a;
    bf16_t b;
  } bf16_op_t;

  // Exponent all-ones: NaN or Inf input.
  function automatic logic bf16_is_special(input bf16_t x);
    return x[14:7] == 8'hFF;
  endfunction
endpackage

// File: rtl/bfloat_add_comb.sv
// Combinational bfloat16 adder: denormals flush to zero, truncating rounding,
// any NaN/Inf input or exponent overflow gives BF16_NAN.
module bfloat_add_comb
  import bfloat_pkg::*;
(
  input  logic [BF16_W-1:0] a,
  input  logic [BF16_W-1:0] b,
  output logic [BF16_W-1:0] y
);
  logic        swap, sl, ss, fnd;
  logic [7:0]  el, es, d, ey;
  logic [10:0] ml, ms, msh, diff, norm;
  logic [11:0] sum;
  logic [3:0]  lz;
  logic [6:0]  my;

  // Align smaller magnitude to larger, add or subtract, renormalise.
  always_comb begin
    y    = BF16_ZERO;
    fnd  = 1'b0;
    lz   = '0;
    ey   = '0;
    my   = '0;
    norm = '0;
    swap = a[14:0] < b[14:0];
    sl   = swap ? b[15]    : a[15];
    ss   = swap ? a[15]    : b[15];
    el   = swap ? b[14:7]  : a[14:7];
    es   = swap ? a[14:7]  : b[14:7];
    // Hidden bit plus 3 low guard positions; zero exponent reads as 0.0.
    ml   = (el != 8'd0) ? {1'b1, (swap ? b[6:0] : a[6:0]), 3'b000} : 11'd0;
    ms   = (es != 8'd0) ? {1'b1, (swap ? a[6:0] : b[6:0]), 3'b000} : 11'd0;
    d    = el - es;
    msh  = (d > 8'd10) ? 11'd0 : (ms >> d);
    sum  = {1'b0, ml} + {1'b0, msh};
    diff = ml - msh;
    for (int i = 10; i >= 0; i--) begin
      if (!fnd && diff[i]) begin
        fnd = 1'b1;
        lz  = 4'(10 - i);
      end
    end

    if (bf16_is_special(a) || bf16_is_special(b)) begin
      y = BF16_NAN;
    end else if (a[14:7] == 8'd0 && b[14:7] == 8'd0) begin
      y = BF16_ZERO;
    end else if (sl == ss) begin
      if (sum[11]) begin
        if (el == 8'hFE) begin
          y = BF16_NAN;
        end else begin
          ey = el + 8'd1;
          my = sum[10:4];
          y  = {sl, ey, my};
        end
      end else begin
        y = {sl, el, sum[9:3]};
      end
    end else if (diff != 11'd0 && {4'b0, lz} < el) begin
      ey   = el - {4'b0, lz};
      norm = diff << lz;
      my   = norm[9:3];
      y    = {sl, ey, my};
    end
  end
endmodule

// File: rtl/rr_arb.sv
// Round-robin arbiter: first set req at or after ptr, wrapping N-1 -> 0.
module rr_arb #(
  parameter  int N = 4,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  input  logic         en,
  output logic [N-1:0] gnt,
  output logic [W-1:0] gnt_id
);
  logic         found;
  logic [W:0]   s;
  logic [W-1:0] idx;

  // Scan N positions starting at ptr; first pending request wins.
  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    found  = 1'b0;
    s      = '0;
    idx    = '0;
    for (int i = 0; i < N; i++) begin
      s = (W+1)'(ptr) + (W+1)'(i);
      if (s >= (W+1)'(N)) s = s - (W+1)'(N);
      idx = s[W-1:0];
      if (en && !found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        gnt_id   = idx;
      end
    end
  end
endmodule

// File: rtl/bfloat_add_arb.sv
// One bfloat16 adder shared by NREQ requesters, round-robin, latency 1.
module bfloat_add_arb
  import bfloat_pkg::*;
#(
  parameter  int NREQ  = 4,
  parameter  int CNT_W = 16,
  localparam int ID_W  = $clog2(NREQ)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         en,
  input  logic [NREQ-1:0]              req_valid,
  input  logic [NREQ-1:0][BF16_W-1:0]  req_a,
  input  logic [NREQ-1:0][BF16_W-1:0]  req_b,
  output logic [NREQ-1:0]              req_ready,
  output logic                         rsp_valid,
  output logic [ID_W-1:0]              rsp_id,
  output logic [BF16_W-1:0]            rsp_data,
  output logic [CNT_W-1:0]             op_count
);
  logic [NREQ-1:0]   gnt;
  logic [ID_W-1:0]   gnt_id, rr_ptr;
  logic              hs;
  bf16_op_t          op_d, op_q;
  logic [BF16_W-1:0] sum;

  rr_arb #(.N(NREQ)) u_arb (
    .req    (req_valid),
    .ptr    (rr_ptr),
    .en     (en),
    .gnt    (gnt),
    .gnt_id (gnt_id)
  );

  assign req_ready = gnt;
  assign hs        = |(req_valid & gnt);

  // Operand mux: winner's operands, zeros when nothing is granted.
  always_comb begin
    op_d = '0;
    if (hs) begin
      op_d.a = req_a[gnt_id];
      op_d.b = req_b[gnt_id];
    end
  end

  // Handshake: capture operands, advance pointer and counter, flag response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr    <= '0;
      op_count  <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      op_q      <= '0;
    end else begin
      rsp_valid <= hs;
      if (hs) begin
        rr_ptr   <= (gnt_id == ID_W'(NREQ-1)) ? '0 : gnt_id + ID_W'(1);
        op_count <= op_count + CNT_W'(1);
        rsp_id   <= gnt_id;
        op_q     <= op_d;
      end
    end
  end

  bfloat_add_comb u_add (
    .a (op_q.a),
    .b (op_q.b),
    .y (sum)
  );

  assign rsp_data = rsp_valid ? sum : BF16_ZERO;
endmodule

// File: tb/tb_bfloat_add_arb.sv
// Directed bench for bfloat_add_arb: reset, fairness, wrap/skip, en gating,
// adder corner values, reset mid-op.
module tb_bfloat_add_arb;
  localparam int NREQ = 4;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 en;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0][15:0] req_a, req_b;
  logic [NREQ-1:0]      req_ready;
  logic                 rsp_valid;
  logic [1:0]           rsp_id;
  logic [15:0]          rsp_data;
  logic [15:0]          op_count;

  int n_tests = 0;
  int n_fail  = 0;

  bfloat_add_arb #(.NREQ(NREQ), .CNT_W(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .op_count  (op_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n = 1'b0; en = 1'b0; req_valid = '0; req_a = '0; req_b = '0;
    tick; tick;
    rst_n = 1'b1;
    #1;
  endtask

  // Single op on requester id; returns registered response one cycle later.
  task automatic one_op(input int id, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] exp, input string tag);
    req_a[id] = a; req_b[id] = b; req_valid = '0; req_valid[id] = 1'b1; en = 1'b1;
    #1;
    chk({tag, "_rdy"}, 32'(req_ready), 32'(1 << id));
    tick;
    req_valid = '0;
    #1;
    chk({tag, "_vld"}, 32'(rsp_valid), 32'd1);
    chk({tag, "_id"},  32'(rsp_id),    32'(id));
    chk({tag, "_dat"}, 32'(rsp_data),  32'(exp));
  endtask

  logic [15:0] fa [4] = '{16'h3F80, 16'h4000, 16'h4040, 16'h4080};
  logic [15:0] va [7] = '{16'hFF80, 16'h0000, 16'h3F80, 16'h4000, 16'h3F80, 16'hBF80, 16'h7F7F};
  logic [15:0] vb [7] = '{16'h3F80, 16'h0000, 16'h3F80, 16'h3F80, 16'hBF80, 16'h3F00, 16'h7F7F};
  logic [15:0] vy [7] = '{16'hFFFF, 16'h0000, 16'h4000, 16'h4040, 16'h0000, 16'hBF00, 16'hFFFF};

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    // Reset state
    rst_n = 1'b0; en = 1'b0; req_valid = '0; req_a = '0; req_b = '0;
    tick; tick;
    chk("rst_vld", 32'(rsp_valid), 32'd0);
    chk("rst_id",  32'(rsp_id),    32'd0);
    chk("rst_dat", 32'(rsp_data),  32'd0);
    chk("rst_cnt", 32'(op_count),  32'd0);
    chk("rst_rdy", 32'(req_ready), 32'd0);
    rst_n = 1'b1;
    #1;

    // 1. Single op
    one_op(0, 16'h0000, 16'h3F80, 16'h3F80, "t1");
    chk("t1_cnt", 32'(op_count), 32'd1);
    tick;
    chk("t1_pulse", 32'(rsp_valid), 32'd0);
    chk("t1_gate",  32'(rsp_data),  32'd0);

    // 2. Fairness with all four pending
    do_reset;
    for (int i = 0; i < NREQ; i++) begin
      req_a[i] = fa[i]; req_b[i] = 16'h0000;
    end
    req_valid = 4'b1111; en = 1'b1;
    for (int c = 0; c < 8; c++) begin
      #1;
      chk($sformatf("t2_rdy%0d", c), 32'(req_ready), 32'(1 << (c % 4)));
      tick;
      if (c == 7) req_valid = '0;
      #1;
      chk($sformatf("t2_vld%0d", c), 32'(rsp_valid), 32'd1);
      chk($sformatf("t2_id%0d", c),  32'(rsp_id),    32'(c % 4));
      chk($sformatf("t2_dat%0d", c), 32'(rsp_data),  32'(fa[c % 4]));
    end
    chk("t2_cnt", 32'(op_count), 32'd8);

    // 3. Wrap/skip: one grant to 2 sets ptr=3; then only 1 -> grant 1 (ptr=2)
    one_op(2, 16'h3F80, 16'h0000, 16'h3F80, "t3a");
    one_op(1, 16'h4000, 16'h0000, 16'h4000, "t3b");
    req_valid = 4'b1001;
    #1;
    chk("t3_rdy", 32'(req_ready), 32'b1000);
    tick;
    req_valid = '0;
    #1;
    chk("t3_id",  32'(rsp_id),   32'd3);
    chk("t3_cnt", 32'(op_count), 32'd11);

    // 4. en gating with an op in flight
    req_a[0] = 16'h3F80; req_b[0] = 16'h3F80;
    req_valid = 4'b0001; en = 1'b1;
    #1;
    chk("t4_rdy", 32'(req_ready), 32'b0001);
    tick;
    en = 1'b0; req_a[1] = 16'h4000; req_b[1] = 16'h0000; req_valid = 4'b0010;
    #1;
    chk("t4_vld",  32'(rsp_valid), 32'd1);
    chk("t4_dat",  32'(rsp_data),  32'h4000);
    chk("t4_rdy0", 32'(req_ready), 32'd0);
    tick;
    chk("t4_vld1", 32'(rsp_valid), 32'd0);
    chk("t4_rdy1", 32'(req_ready), 32'd0);
    tick;
    chk("t4_cnt",  32'(op_count),  32'd12);
    en = 1'b1;
    #1;
    chk("t4_rdy2", 32'(req_ready), 32'b0010);
    tick;
    req_valid = '0;
    #1;
    chk("t4_id", 32'(rsp_id), 32'd1);

    // 5. Adder corner values
    for (int v = 0; v < 7; v++) begin
      one_op(2, va[v], vb[v], vy[v], $sformatf("t5_%0d", v));
    end

    // 6. Reset between handshake and response
    req_a[3] = 16'h3F80; req_b[3] = 16'h3F80; req_valid = 4'b1000; en = 1'b1;
    @(posedge clk);
    req_valid = '0;
    #1;
    rst_n = 1'b0;
    #1;
    chk("t6_vld", 32'(rsp_valid), 32'd0);
    chk("t6_cnt", 32'(op_count),  32'd0);
    chk("t6_id",  32'(rsp_id),    32'd0);
    tick;
    chk("t6_vld1", 32'(rsp_valid), 32'd0);
    rst_n = 1'b1;
    req_valid = 4'b1111;
    #1;
    chk("t6_ptr", 32'(req_ready), 32'b0001);
    req_valid = '0;
    tick;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
